// File: rtl/alu_sweep_checker.sv
// Sweeps A/B/opcode into an ALU and checks the result and flags against a golden model after ALU_LATENCY cycles.
// Optional ALU_CHK_STOP_ON_ERR_EN: stop issuing vectors on the first mismatch, then drain and finish.
//   state  | meaning
//   IDLE   | waiting for start after reset
//   RUN    | presenting one vector per cycle
//   DRAIN  | no new vectors; comparing the in-flight results
//   DONE   | sweep finished, done held high
module alu_sweep_checker #(
   parameter int WIDTH       = 16,
   parameter int STEP        = 16,
   parameter int ALU_LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op_lo,
   input  logic [2:0]       op_hi,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [2:0]       opcode,
   input  logic [WIDTH-1:0] result,
   input  logic             carryout,
   input  logic             overflow,
   input  logic             zero,
   output logic             busy,
   output logic             done,
   output logic [15:0]      err_count,
   output logic             fail_valid,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b,
   output logic [2:0]       fail_op
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
   localparam int             LAST   = ALU_LATENCY - 1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a, r_b;
   logic [2:0]       r_op, r_op_last;
   logic [1:0]       r_drain_cnt;
   logic [15:0]      r_err;
   logic             r_fail_valid;
   logic [WIDTH-1:0] r_fail_a, r_fail_b;
   logic [2:0]       r_fail_op;

   logic             r_pv   [ALU_LATENCY];
   logic [WIDTH-1:0] r_pres [ALU_LATENCY];
   logic             r_pc   [ALU_LATENCY];
   logic             r_po   [ALU_LATENCY];
   logic [2:0]       r_pop  [ALU_LATENCY];
   logic [WIDTH-1:0] r_pa   [ALU_LATENCY];
   logic [WIDTH-1:0] r_pb   [ALU_LATENCY];

   logic [WIDTH:0]   w_sum, w_diff, w_a_nxt, w_b_nxt;
   logic [WIDTH-1:0] w_exp_res;
   logic             w_exp_c, w_exp_v;
   logic             w_a_wrap, w_b_wrap, w_last, w_mismatch;

   // golden model for the vector currently on A/B/opcode
   always_comb begin
      w_sum     = {1'b0, r_a} + {1'b0, r_b};
      w_diff    = {1'b0, r_a} - {1'b0, r_b};
      w_exp_res = '0;
      w_exp_c   = 1'b0;
      w_exp_v   = 1'b0;
      case (r_op)
         3'd0: begin
            w_exp_res = w_sum[WIDTH-1:0];
            w_exp_c   = w_sum[WIDTH];
         end
         3'd1: begin
            w_exp_res = w_sum[WIDTH-1:0];
            w_exp_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         3'd2: begin
            w_exp_res = w_diff[WIDTH-1:0];
            w_exp_c   = (r_a < r_b);
         end
         3'd3: begin
            w_exp_res = w_diff[WIDTH-1:0];
            w_exp_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
         end
         3'd4:    w_exp_res = r_a & r_b;
         3'd5:    w_exp_res = r_a | r_b;
         3'd6:    w_exp_res = r_a ^ r_b;
         default: w_exp_res = r_a >> 1;
      endcase
   end

   always_comb begin
      w_mismatch = 1'b0;
      if (r_pv[LAST]) begin
         w_mismatch = (result != r_pres[LAST]) || (zero != (r_pres[LAST] == '0));
         if ((r_pop[LAST] == 3'd0) || (r_pop[LAST] == 3'd2))
            w_mismatch = w_mismatch || (carryout != r_pc[LAST]);
         if ((r_pop[LAST] == 3'd1) || (r_pop[LAST] == 3'd3))
            w_mismatch = w_mismatch || (overflow != r_po[LAST]);
      end
   end

   assign w_b_nxt  = {1'b0, r_b} + STEP_W;
   assign w_a_nxt  = {1'b0, r_a} + STEP_W;
   assign w_b_wrap = w_b_nxt[WIDTH];
   assign w_a_wrap = w_a_nxt[WIDTH];
   assign w_last   = w_b_wrap && w_a_wrap && (r_op == r_op_last);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_last) w_state_nxt = S_DRAIN;
`ifdef ALU_CHK_STOP_ON_ERR_EN
            else if (w_mismatch) w_state_nxt = S_DRAIN;
`endif
         end
         S_DRAIN: if (r_drain_cnt == 2'd0) w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == S_RUN) || (r_state == S_DRAIN);
      done = (r_state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a <= '0; r_b <= '0; r_op <= '0; r_op_last <= '0;
         r_drain_cnt <= '0; r_err <= '0;
         r_fail_valid <= 1'b0; r_fail_a <= '0; r_fail_b <= '0; r_fail_op <= '0;
         for (int i = 0; i < ALU_LATENCY; i++) begin
            r_pv[i] <= 1'b0; r_pres[i] <= '0; r_pc[i] <= 1'b0; r_po[i] <= 1'b0;
            r_pop[i] <= '0; r_pa[i] <= '0; r_pb[i] <= '0;
         end
      end else begin
         r_pv[0]   <= (r_state == S_RUN);
         r_pres[0] <= w_exp_res;
         r_pc[0]   <= w_exp_c;
         r_po[0]   <= w_exp_v;
         r_pop[0]  <= r_op;
         r_pa[0]   <= r_a;
         r_pb[0]   <= r_b;
         for (int i = 1; i < ALU_LATENCY; i++) begin
            r_pv[i] <= r_pv[i-1]; r_pres[i] <= r_pres[i-1]; r_pc[i] <= r_pc[i-1];
            r_po[i] <= r_po[i-1]; r_pop[i] <= r_pop[i-1]; r_pa[i] <= r_pa[i-1];
            r_pb[i] <= r_pb[i-1];
         end

         if (((r_state == S_IDLE) || (r_state == S_DONE)) && start) begin
            r_a <= '0; r_b <= '0; r_op <= op_lo;
            r_op_last <= (op_hi < op_lo) ? op_lo : op_hi;
            r_err <= '0;
            r_fail_valid <= 1'b0; r_fail_a <= '0; r_fail_b <= '0; r_fail_op <= '0;
         end else begin
            if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
               if (!w_b_wrap) r_b <= w_b_nxt[WIDTH-1:0];
               else begin
                  r_b <= '0;
                  if (!w_a_wrap) r_a <= w_a_nxt[WIDTH-1:0];
                  else begin
                     r_a  <= '0;
                     r_op <= r_op + 3'd1;
                  end
               end
            end
            if (w_mismatch) begin
               if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
               if (!r_fail_valid) begin
                  r_fail_valid <= 1'b1;
                  r_fail_a     <= r_pa[LAST];
                  r_fail_b     <= r_pb[LAST];
                  r_fail_op    <= r_pop[LAST];
               end
            end
         end

         // drain down-counter: ALU_LATENCY cycles in DRAIN
         if ((w_state_nxt == S_DRAIN) && (r_state != S_DRAIN))
            r_drain_cnt <= 2'(LAST);
         else if ((r_state == S_DRAIN) && (r_drain_cnt != 2'd0))
            r_drain_cnt <= r_drain_cnt - 2'd1;
      end
   end

   assign A          = r_a;
   assign B          = r_b;
   assign opcode     = r_op;
   assign err_count  = r_err;
   assign fail_valid = r_fail_valid;
   assign fail_a     = r_fail_a;
   assign fail_b     = r_fail_b;
   assign fail_op    = r_fail_op;

endmodule
